// File: rtl/instr_issue_queue_pkg.sv
// Shared types and constants for the instruction issue queue.
// Instruction/address widths and default queue sizing.
package instr_issue_queue_pkg;

    localparam int INSTR_WIDTH       = 32;
    localparam int ADDR_WIDTH_DEF    = 32;
    localparam int QUEUE_DEPTH_LOG_DEF = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [INSTR_WIDTH-1:0] instr_t;

endpackage

// File: rtl/instr_issue_queue_ram.sv
// Storage array for the issue queue: {instr, pc} per entry.
// Synchronous write at tail, asynchronous read at head.
module instr_issue_queue_ram
    import instr_issue_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH_LOG = QUEUE_DEPTH_LOG_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [QUEUE_DEPTH_LOG-1:0] wr_addr,
    input  logic [INSTR_WIDTH-1:0]     wr_instr,
    input  logic [ADDR_WIDTH-1:0]      wr_pc,
    input  logic [QUEUE_DEPTH_LOG-1:0] rd_addr,
    output logic [INSTR_WIDTH-1:0]     rd_instr,
    output logic [ADDR_WIDTH-1:0]      rd_pc
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

    // Write the incoming entry; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[wr_addr] <= wr_instr;
            pc_mem[wr_addr]    <= wr_pc;
        end
    end

    assign rd_instr = instr_mem[rd_addr];
    assign rd_pc    = pc_mem[rd_addr];

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers fetched instructions and issues
// one per cycle to the decoder through a registered output stage.
module instr_issue_queue
    import instr_issue_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH_LOG = QUEUE_DEPTH_LOG_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     update_stat,
    input  logic                     fetch_valid,
    input  logic [INSTR_WIDTH-1:0]   fetch_instr,
    input  logic [ADDR_WIDTH-1:0]    fetch_pc,
    output logic                     queue_full,
    input  logic                     issue_stall,
    output logic                     decode_enable,
    output logic [INSTR_WIDTH-1:0]   instr_out,
    output logic [ADDR_WIDTH-1:0]    pc_out,
    output logic [QUEUE_DEPTH_LOG:0] count
);

    localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;
    localparam logic [QUEUE_DEPTH_LOG:0] FULL_CNT = DEPTH[QUEUE_DEPTH_LOG:0];
    localparam logic [QUEUE_DEPTH_LOG:0] CNT_ONE  = {{QUEUE_DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [QUEUE_DEPTH_LOG-1:0] PTR_ONE =
        {{(QUEUE_DEPTH_LOG-1){1'b0}}, 1'b1};

    logic [QUEUE_DEPTH_LOG-1:0] head;
    logic [QUEUE_DEPTH_LOG-1:0] tail;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic [INSTR_WIDTH-1:0]     head_instr;
    logic [ADDR_WIDTH-1:0]      head_pc;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign queue_full = full;

    // Full is judged on the current count: a same-cycle pop frees no room.
    assign push = fetch_valid && !full && rdy && !update_stat;
    assign pop  = !empty && !issue_stall && rdy && !update_stat;

    instr_issue_queue_ram #(
        .QUEUE_DEPTH_LOG (QUEUE_DEPTH_LOG),
        .ADDR_WIDTH      (ADDR_WIDTH)
    ) u_ram (
        .clk      (clk),
        .wr_en    (push),
        .wr_addr  (tail),
        .wr_instr (fetch_instr),
        .wr_pc    (fetch_pc),
        .rd_addr  (head),
        .rd_instr (head_instr),
        .rd_pc    (head_pc)
    );

    // Pointers and occupancy; flush clears them only while rdy is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy && update_stat) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Output register to the decoder; data holds whenever nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decode_enable <= FALSE;
            instr_out     <= '0;
            pc_out        <= '0;
        end else begin
            decode_enable <= pop;
            if (pop) begin
                instr_out <= head_instr;
                pc_out    <= head_pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_instr_issue_queue;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        update_stat;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        queue_full;
    logic        issue_stall;
    logic        decode_enable;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    instr_issue_queue #(
        .QUEUE_DEPTH_LOG (4),
        .ADDR_WIDTH      (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .update_stat   (update_stat),
        .fetch_valid   (fetch_valid),
        .fetch_instr   (fetch_instr),
        .fetch_pc      (fetch_pc),
        .queue_full    (queue_full),
        .issue_stall   (issue_stall),
        .decode_enable (decode_enable),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fetch(input logic v, input logic [31:0] ins,
                             input logic [31:0] pc);
        fetch_valid = v;
        fetch_instr = ins;
        fetch_pc    = pc;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        update_stat = 1'b0;
        issue_stall = 1'b0;
        set_fetch(1'b0, 32'h0, 32'h0);
        #2;
        check("rst_count", count, 0);
        check("rst_dec", decode_enable, 0);
        check("rst_instr", instr_out, 0);
        check("rst_pc", pc_out, 0);
        check("rst_full", queue_full, 0);
        tick();
        rst = 1'b0;

        // Basic issue
        set_fetch(1'b1, 32'h00500093, 32'h0);
        tick();
        set_fetch(1'b0, 32'h0, 32'h0);
        check("basic_cnt1", count, 1);
        check("basic_nodec", decode_enable, 0);
        tick();
        check("basic_dec", decode_enable, 1);
        check("basic_instr", instr_out, 32'h00500093);
        check("basic_pc", pc_out, 32'h0);
        check("basic_cnt0", count, 0);
        tick();
        check("basic_dec_off", decode_enable, 0);
        check("basic_hold", instr_out, 32'h00500093);

        // Fill under stall
        issue_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_fetch(1'b1, 32'h1000 + i, 32'(i * 4));
            tick();
        end
        check("fill_cnt", count, 16);
        check("fill_full", queue_full, 1);
        check("fill_nodec", decode_enable, 0);
        set_fetch(1'b1, 32'hdead, 32'h40);
        tick();
        check("drop17_cnt", count, 16);

        // Push at full with pop: incoming dropped, next push accepted
        issue_stall = 1'b0;
        set_fetch(1'b1, 32'hbeef, 32'h80);
        tick();
        check("fullpop_dec", decode_enable, 1);
        check("fullpop_pc", pc_out, 32'h0);
        check("fullpop_cnt", count, 15);
        check("fullpop_nfull", queue_full, 0);
        set_fetch(1'b1, 32'hcafe, 32'h84);
        tick();
        check("pp_pc", pc_out, 32'h4);
        check("pp_instr", instr_out, 32'h1001);
        check("pp_cnt", count, 15);
        set_fetch(1'b0, 32'h0, 32'h0);
        for (int i = 2; i < 16; i++) begin
            tick();
            check("drain_dec", decode_enable, 1);
            check("drain_pc", pc_out, 32'(i * 4));
        end
        tick();
        check("drain_last_pc", pc_out, 32'h84);
        check("drain_last_instr", instr_out, 32'hcafe);
        check("drain_cnt", count, 0);
        tick();
        check("drain_idle", decode_enable, 0);

        // Wrap: push/pop pairs across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            set_fetch(1'b1, 32'h2000 + i, 32'(i * 4));
            tick();
            if (i > 0) begin
                check("wrap_dec", decode_enable, 1);
                check("wrap_pc", pc_out, 32'((i - 1) * 4));
            end
            check("wrap_cnt", count, 1);
        end
        set_fetch(1'b0, 32'h0, 32'h0);
        tick();
        check("wrap_last_pc", pc_out, 32'h4c);
        check("wrap_last_instr", instr_out, 32'h2013);
        check("wrap_cnt0", count, 0);
        tick();

        // Flush with concurrent fetch
        issue_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_fetch(1'b1, 32'h3000 + i, 32'h200 + 32'(i * 4));
            tick();
        end
        check("fl_cnt5", count, 5);
        issue_stall = 1'b0;
        update_stat = 1'b1;
        set_fetch(1'b1, 32'h3333, 32'h300);
        tick();
        update_stat = 1'b0;
        set_fetch(1'b0, 32'h0, 32'h0);
        check("fl_cnt0", count, 0);
        check("fl_dec", decode_enable, 0);
        check("fl_pc_hold", pc_out, 32'h4c);
        check("fl_full", queue_full, 0);
        tick();
        check("fl_noissue", decode_enable, 0);
        check("fl_cnt_still0", count, 0);
        set_fetch(1'b1, 32'h4444, 32'h100);
        tick();
        set_fetch(1'b0, 32'h0, 32'h0);
        check("fl_push_cnt", count, 1);
        check("fl_push_nodec", decode_enable, 0);
        tick();
        check("fl_issue_dec", decode_enable, 1);
        check("fl_issue_pc", pc_out, 32'h100);
        tick();

        // rdy freeze
        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_fetch(1'b1, 32'h5000 + i, 32'h400 + 32'(i * 4));
            tick();
        end
        issue_stall = 1'b0;
        rdy = 1'b0;
        set_fetch(1'b1, 32'h6666, 32'h600);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rdy_cnt", count, 3);
            check("rdy_dec", decode_enable, 0);
        end
        rdy = 1'b1;
        set_fetch(1'b0, 32'h0, 32'h0);
        tick();
        check("rdy_resume_dec", decode_enable, 1);
        check("rdy_resume_pc", pc_out, 32'h400);
        check("rdy_resume_cnt", count, 2);

        // issue_stall freeze: pushes still accepted
        issue_stall = 1'b1;
        set_fetch(1'b1, 32'h7777, 32'h500);
        tick();
        set_fetch(1'b0, 32'h0, 32'h0);
        check("st_dec", decode_enable, 0);
        check("st_cnt", count, 3);
        check("st_pc_hold", pc_out, 32'h400);
        tick();
        check("st_dec2", decode_enable, 0);
        issue_stall = 1'b0;
        tick();
        check("st_pc1", pc_out, 32'h404);
        tick();
        check("st_pc2", pc_out, 32'h408);
        tick();
        check("st_pc3", pc_out, 32'h500);
        check("st_instr3", instr_out, 32'h7777);
        check("st_cnt0", count, 0);
        tick();
        check("st_idle", decode_enable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Buffers fetched instructions and their PCs from the instruction fetch unit.
- Sequences them one per cycle into the decoder; the decoder's result appears one cycle after this block's issue.
- Holds issue whenever downstream structures (ROB/RS/LSB) signal stall.
- Flushes all buffered and in-flight state on update_stat (branch mispredict / pipeline clear).

Parameters:
QUEUE_DEPTH_LOG, 4, log2 of queue entries (default 16 entries)
ADDR_WIDTH, 32, width of PC values

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
rdy  input  1  global ready; low freezes the block
update_stat  input  1  flush request, highest priority after rst
fetch_valid  input  1  fetch unit presents an instruction this cycle
fetch_instr  input  32  instruction word (`InstrType)
fetch_pc  input  ADDR_WIDTH  PC of fetch_instr
queue_full  output  1  combinational; count == 2**QUEUE_DEPTH_LOG
issue_stall  input  1  downstream cannot accept a decoded instruction
decode_enable  output  1  registered; one-cycle pulse per issued instruction
instr_out  output  32  registered instruction to decoder
pc_out  output  ADDR_WIDTH  registered PC travelling with instr_out
count  output  QUEUE_DEPTH_LOG+1  current occupancy

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-high.
- Reset (rst high, asynchronous): head=0, tail=0, count=0, decode_enable=0, instr_out=0, pc_out=0. Storage contents are don't-care.
- Circular buffer of 2**QUEUE_DEPTH_LOG entries. Each entry holds {instr, pc}.
- head and tail are QUEUE_DEPTH_LOG bits wide and wrap modulo depth. count is tracked separately.
  - empty: count == 0.
  - full: count == depth.
- push = fetch_valid && !full && rdy && !update_stat.
  - Writes the entry at tail; tail increments.
  - full is evaluated from the current count. A simultaneous pop does not make room for a push in the same cycle.
- pop = !empty && !issue_stall && rdy && !update_stat.
  - Next edge: instr_out/pc_out take the entry at head, decode_enable=1, head increments.
- When pop is 0: decode_enable=0 next edge; instr_out/pc_out hold their values.
- count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- No bypass. Latency is: instruction pushed at edge N, earliest issue (decode_enable high) after edge N+1, decoder result after edge N+2.
- Flush (update_stat high at an edge with rdy high):
  - head=tail=count=0 and decode_enable=0.
  - Any concurrent fetch is dropped.
  - instr_out/pc_out hold their values.
  - queue_full deasserts combinationally once count is 0.
- rdy low: no push, no pop, no flush, and decode_enable=0 next edge. All other state holds.
- issue_stall is sampled at the issuing edge. A stall raised in the same cycle as a would-be pop blocks that pop.
- Wrap-around: after 16 pushes and 16 pops, head=tail=0 again with count=0. Ordering is strictly FIFO across the wrap.
- Priority: rst > update_stat > rdy-low > normal push/pop.

Decomposition:
- Shared defines file (`defines.v`):
  - `InstrType [31:0]`, `AddrType [31:0]`
  - `True`/`False`
  - `QueueDepthLog` default 4
- One natural sub-module: `instr_queue_ram`. It holds the storage array, with a synchronous write port and an asynchronous read at head.
- Pointer logic, count logic and the output register stay in instr_issue_queue.

Test Plan:
- Basic issue: reset, push instr 0x00500093 pc 0x0 at edge 1 → decode_enable=1 after edge 2, instr_out=0x00500093, pc_out=0x0; decode_enable=0 after edge 3.
- Fill: hold issue_stall=1 and push 16 instructions with pc 0x0..0x3C → count=16, queue_full=1. A 17th push with pc 0x40 is dropped: count stays 16, and after release that instruction never issues.
- Push at full with pop: full queue, issue_stall=0, fetch_valid=1 → one issue, count=15, incoming instruction dropped. Next cycle a push is accepted.
- Wrap: 20 push/pop pairs at pc 0x0..0x4C → pc_out sequence is strictly 0x0..0x4C in order, with no gaps or duplicates across the head/tail wrap.
- Flush: count=5, pulse update_stat with fetch_valid=1 → count=0 next edge, decode_enable=0, no issue until a new push. That push of pc 0x100 issues 2 edges later.
- rdy/stall freeze: count=3, rdy=0 for 4 cycles → count stays 3, decode_enable stays 0. After rdy returns to 1, issue resumes with the original head pc. issue_stall=1 behaves the same, except that pushes continue to be accepted.
